// File: rtl/ysyx_25060173_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25060173_mem_pkg
// Brief    : Shared types and constants for the physical-memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package ysyx_25060173_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic REQ_IFU = 1'b0;
    localparam logic REQ_LSU = 1'b1;

    localparam int DEFAULT_ADDR_W = 32;
    localparam int DEFAULT_DATA_W = 32;

endpackage
`default_nettype wire

// File: rtl/ysyx_25060173_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25060173_rr_picker
// Brief    : Two-way round-robin selector; bit 0 = IFU, bit 1 = LSU.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_25060173_rr_picker
    import ysyx_25060173_mem_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (valid == 2'b11) begin
            // On a tie, the requester that was not served last time wins.
            grant = (last == REQ_LSU) ? 2'b01 : 2'b10;
        end else begin
            grant = valid;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ysyx_25060173_pmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25060173_pmem_arbiter
// Brief    : Round-robin IFU/LSU arbiter for the single physical-memory port,
//            one outstanding transaction, with a response watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_25060173_pmem_arbiter
    import ysyx_25060173_mem_pkg::*;
#(
    parameter int ADDR_W         = DEFAULT_ADDR_W,
    parameter int DATA_W         = DEFAULT_DATA_W,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic                ifu_resp_err,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic                lsu_we,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_resp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_resp_err,
    output logic                busy
);

    localparam int                c_mask_w    = DATA_W / 8;
    localparam int                c_wdog_w    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_wdog_w-1:0] c_wdog_last = c_wdog_w'(TIMEOUT_CYCLES - 1);
    localparam logic [c_wdog_w-1:0] c_wdog_max  = '1;

    state_t              r_state;
    logic                r_owner;
    logic                r_last_grant;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [c_mask_w-1:0] r_wmask;
    logic [c_wdog_w-1:0] r_wdog;

    logic [1:0]          w_grant;
    logic                w_idle;
    logic                w_accept;
    logic                w_win_lsu;
    logic                w_resp_fire;
    logic                w_resp_err;
    logic [DATA_W-1:0]   w_resp_rdata;

    ysyx_25060173_rr_picker u_picker (
        .valid (  {lsu_req_valid, ifu_req_valid}),
        .last  (r_last_grant),
        .grant (w_grant)
    );

    // Ready is held low while reset is asserted so every output reads 0.
    assign w_idle        = reset && (r_state == IDLE);
    assign ifu_req_ready = w_idle && w_grant[0];
    assign lsu_req_ready = w_idle && w_grant[1];
    assign w_accept      = ifu_req_ready || lsu_req_ready;
    assign w_win_lsu     = w_grant[1];

    assign mem_req_valid = (r_state == REQ);
    assign mem_we        = r_we;
    assign mem_addr      = r_addr;
    assign mem_wdata     = r_wdata;
    assign mem_wmask     = r_wmask;
    assign busy          = (r_state != IDLE);

    // A real response in the timeout cycle takes priority over the watchdog.
    assign w_resp_fire  = (r_state == WAIT) && (mem_resp_valid || (r_wdog == c_wdog_last));
    assign w_resp_err   = mem_resp_valid ? mem_resp_err : 1'b1;
    assign w_resp_rdata = (mem_resp_valid && !r_we) ? mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_owner        <= REQ_IFU;
            r_last_grant   <= REQ_LSU;
            r_we           <= 1'b0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_wmask        <= '0;
            r_wdog         <= '0;
            ifu_resp_valid <= 1'b0;
            ifu_rdata      <= '0;
            ifu_resp_err   <= 1'b0;
            lsu_resp_valid <= 1'b0;
            lsu_rdata      <= '0;
            lsu_resp_err   <= 1'b0;
        end else begin
            ifu_resp_valid <= 1'b0;
            lsu_resp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_owner      <= w_win_lsu ? REQ_LSU : REQ_IFU;
                        r_last_grant <= w_win_lsu ? REQ_LSU : REQ_IFU;
                        r_we         <= w_win_lsu ? lsu_we : 1'b0;
                        r_addr       <= w_win_lsu ? lsu_addr : ifu_addr;
                        r_wdata      <= w_win_lsu ? lsu_wdata : '0;
                        r_wmask      <= w_win_lsu ? lsu_wmask : '0;
                        r_state      <= REQ;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        r_wdog  <= '0;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (w_resp_fire) begin
                        if (r_owner == REQ_LSU) begin
                            lsu_resp_valid <= 1'b1;
                            lsu_rdata      <= w_resp_rdata;
                            lsu_resp_err   <= w_resp_err;
                        end else begin
                            ifu_resp_valid <= 1'b1;
                            ifu_rdata      <= w_resp_rdata;
                            ifu_resp_err   <= w_resp_err;
                        end
                        r_state <= IDLE;
                    end else if (r_wdog != c_wdog_max) begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25060173_pmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_25060173_pmem_arbiter
// Brief    : Self-checking bench: directed and randomized transactions against
//            a transaction-level reference model of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_25060173_pmem_arbiter;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ifu_req_valid = 1'b0, ifu_req_ready;
    logic [31:0] ifu_addr = '0;
    logic        ifu_resp_valid, ifu_resp_err;
    logic [31:0] ifu_rdata;
    logic        lsu_req_valid = 1'b0, lsu_req_ready, lsu_we = 1'b0;
    logic [31:0] lsu_addr = '0, lsu_wdata = '0;
    logic [3:0]  lsu_wmask = '0;
    logic        lsu_resp_valid, lsu_resp_err;
    logic [31:0] lsu_rdata;
    logic        mem_req_valid, mem_req_ready = 1'b0, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_resp_valid = 1'b0, mem_resp_err = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;
    bit model_last = 1'b1;  // last granted requester: 0 = IFU, 1 = LSU

    always #5 clk = ~clk;

    ysyx_25060173_pmem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .reset(reset),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_we(lsu_we),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .mem_resp_err(mem_resp_err),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction: request, address phase, data phase, response.
    task automatic txn(input string tag, input bit iv, input bit lv, input bit lwe,
                       input logic [31:0] iaddr, input logic [31:0] laddr,
                       input logic [31:0] lwdata, input logic [3:0] lwmask,
                       input int rdy_dly, input int resp_dly,
                       input logic [31:0] mrdata, input bit merr, output bit won_lsu);
        bit          w, real_resp, e_err;
        logic [68:0] e_fields;
        logic [31:0] e_rdata;
        int          stop;
        ifu_req_valid = iv;  ifu_addr  = iaddr;
        lsu_req_valid = lv;  lsu_we    = lwe;   lsu_addr = laddr;
        lsu_wdata     = lwdata; lsu_wmask = lwmask;
        #1;
        w = (iv && lv) ? !model_last : lv;
        chk({tag, "/ready"}, 128'({ifu_req_ready, lsu_req_ready}), 128'({!w, w}));
        model_last = w;
        won_lsu    = w;
        e_fields   = w ? {lwe, laddr, lwdata, lwmask} : {1'b0, iaddr, 32'h0, 4'h0};
        step();
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        for (int d = 0; d <= rdy_dly; d++) begin
            chk({tag, "/mem_req"}, 128'({mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask}),
                128'({1'b1, e_fields}));
            chk({tag, "/req_ctl"}, 128'({ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid, busy}),
                128'(5'b00001));
            mem_req_ready = (d == rdy_dly);
            step();
        end
        mem_req_ready = 1'b0;
        real_resp = (resp_dly <= T - 1);
        stop      = real_resp ? resp_dly : T - 1;
        for (int k = 0; k <= stop; k++) begin
            chk({tag, "/wait"}, 128'({mem_req_valid, ifu_resp_valid, lsu_resp_valid, busy}), 128'(4'b0001));
            mem_resp_valid = (k == resp_dly);
            mem_rdata      = (k == resp_dly) ? mrdata : $urandom;
            mem_resp_err   = (k == resp_dly) ? merr : 1'($urandom);
            step();
        end
        mem_resp_valid = 1'b0;
        e_err   = real_resp ? merr : 1'b1;
        e_rdata = (real_resp && !(w && lwe)) ? mrdata : 32'h0;
        chk({tag, "/resp_v"}, 128'({ifu_resp_valid, lsu_resp_valid, busy}), 128'({!w, w, 1'b0}));
        if (w) chk({tag, "/lsu_resp"}, 128'({lsu_rdata, lsu_resp_err}), 128'({e_rdata, e_err}));
        else   chk({tag, "/ifu_resp"}, 128'({ifu_rdata, ifu_resp_err}), 128'({e_rdata, e_err}));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit       won;
        bit [3:0] seq;
        bit       iv, lv;

        // Reset for two cycles with a stray memory response.
        reset = 1'b0;
        mem_resp_valid = 1'b1; mem_rdata = 32'hCAFEF00D; mem_resp_err = 1'b1;
        step();
        mem_resp_valid = 1'b0;
        step();
        chk("rst_ifu", 128'({ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err}), 128'(0));
        chk("rst_lsu", 128'({lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err}), 128'(0));
        chk("rst_mem", 128'({mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask, busy}), 128'(0));
        reset = 1'b1;
        step();
        chk("post_rst", 128'({ifu_resp_valid, lsu_resp_valid, busy}), 128'(0));

        // Simultaneous requests alternate I, L, I, L starting with IFU.
        for (int i = 0; i < 4; i++) begin
            txn("tie", 1'b1, 1'b1, 1'(i % 2), 32'h8000_0000 + 32'(i * 4), 32'h8000_2000 + 32'(i * 4),
                $urandom, 4'($urandom), 0, 0, $urandom, 1'b0, won);
            seq[i] = won;
        end
        chk("rr_order", 128'(seq), 128'(4'b1010));

        // Plain IFU fetch.
        txn("ifu_rd", 1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 4'h0,
            0, 0, 32'h0010_0073, 1'b0, won);

        // LSU write with a slow memory request handshake.
        txn("lsu_wr", 1'b0, 1'b1, 1'b1, 32'h0, 32'h8000_1000, 32'hDEAD_BEEF, 4'b1111,
            3, 1, 32'h1234_5678, 1'b0, won);

        // Memory never answers: watchdog error, then a stray response is ignored.
        txn("tmo", 1'b0, 1'b1, 1'b0, 32'h0, 32'h8000_3000, 32'h0, 4'h0,
            0, 100, 32'h5555_AAAA, 1'b0, won);
        mem_resp_valid = 1'b1; mem_rdata = 32'hFFFF_FFFF; mem_resp_err = 1'b0;
        step();
        mem_resp_valid = 1'b0;
        chk("stray", 128'({ifu_resp_valid, lsu_resp_valid, busy}), 128'(0));
        step();
        chk("stray2", 128'({ifu_resp_valid, lsu_resp_valid, busy}), 128'(0));

        // Randomized traffic, including memory errors and timeouts.
        for (int i = 0; i < 40; i++) begin
            iv = 1'($urandom);
            lv = iv ? 1'($urandom) : 1'b1;
            txn("rnd", iv, lv, 1'($urandom), $urandom, $urandom, $urandom, 4'($urandom),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 5)), $urandom, 1'($urandom), won);
        end

        // Reset during WAIT drops the transaction; a late response is ignored.
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0100;
        step();
        ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        step();
        chk("mid_wait", 128'({busy, mem_req_valid}), 128'(2'b10));
        reset = 1'b0;
        step();
        reset = 1'b1; model_last = 1'b1;
        mem_resp_valid = 1'b1; mem_rdata = 32'h0BAD_0BAD; mem_resp_err = 1'b0;
        step();
        mem_resp_valid = 1'b0;
        chk("rst_wait", 128'({ifu_resp_valid, lsu_resp_valid, busy}), 128'(0));
        step();
        chk("rst_wait2", 128'({ifu_resp_valid, lsu_resp_valid, busy}), 128'(0));

        // Grant history is cleared by reset: a tie goes to the IFU again.
        txn("rst_tie", 1'b1, 1'b1, 1'b0, 32'h8000_0200, 32'h8000_0300, 32'h0, 4'h0,
            0, 0, 32'h0000_0013, 1'b0, won);
        chk("rst_tie_ifu", 128'(won), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
